// File: rtl/pdfd_tap_ctrl_if.sv
// ============================================================================
//  Module   : pdfd_tap_ctrl_if
//  Brief    : Configuration, decoder and gated-output signals of pdfd_tap_ctrl.
//             Optional io_symCount exists only when PDFD_CTRL_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pdfd_tap_ctrl_if #(
  parameter int NUM_TAPS = 14,
  parameter int TAP_W    = 8
);
  logic             io_cfgValid;
  logic             io_cfgReady;
  logic [3:0]       io_cfgAddr;
  logic [TAP_W-1:0] io_cfgData;
  logic             io_cfgCommit;
  logic             io_cfgErr;
  logic [TAP_W-1:0] io_taps [NUM_TAPS];
  logic             io_pdfdFlush;
  logic [7:0]       io_pdfdData;
  logic             io_pdfdValid;
  logic [7:0]       io_rxData;
  logic             io_rxValid;
  logic [1:0]       io_state;
`ifdef PDFD_CTRL_STATS_EN
  logic [15:0]      io_symCount;
`endif

  modport master (
`ifdef PDFD_CTRL_STATS_EN
    input  io_symCount,
`endif
    output io_cfgValid, io_cfgAddr, io_cfgData, io_cfgCommit,
    output io_pdfdData, io_pdfdValid,
    input  io_cfgReady, io_cfgErr, io_taps, io_pdfdFlush,
    input  io_rxData, io_rxValid, io_state
  );

  modport slave (
`ifdef PDFD_CTRL_STATS_EN
    output io_symCount,
`endif
    input  io_cfgValid, io_cfgAddr, io_cfgData, io_cfgCommit,
    input  io_pdfdData, io_pdfdValid,
    output io_cfgReady, io_cfgErr, io_taps, io_pdfdFlush,
    output io_rxData, io_rxValid, io_state
  );
endinterface

`default_nettype wire

// File: rtl/pdfd_tap_ctrl.sv
// ============================================================================
//  Module   : pdfd_tap_ctrl
//  Brief    : Shadow/live tap bank with atomic commit, decoder flush and
//             warm-up masking. Optional macro: PDFD_CTRL_STATS_EN (io_symCount).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdfd_tap_ctrl #(
  parameter int NUM_TAPS     = 14,
  parameter int TAP_W        = 8,
  parameter int FLUSH_CYCLES = 4,
  parameter int WARMUP_SYMS  = 16
) (
  input  wire logic        clock,
  input  wire logic        reset,
  pdfd_tap_ctrl_if.slave   bus
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int WCW = $clog2(WARMUP_SYMS + 1);

  typedef enum logic [1:0] {
    S_UNCONF = 2'd0,
    S_FLUSH  = 2'd1,
    S_WARMUP = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TAP_W-1:0]    r_shadow     [NUM_TAPS];
  logic [TAP_W-1:0]    r_live       [NUM_TAPS];
  logic [TAP_W-1:0]    w_shadow_nxt [NUM_TAPS];
  logic [NUM_TAPS-1:0] r_mask;
  logic [NUM_TAPS-1:0] w_mask_nxt;
  logic [FCW-1:0]      r_fcnt;
  logic [WCW-1:0]      r_wcnt;
  logic                r_err;
  logic                r_rx_valid;
  logic [7:0]          r_rx_data;
  logic                w_ready;
  logic                w_wr;
  logic                w_addr_ok;
  logic                w_commit_ok;
  logic                w_commit_bad;
  logic                w_flush_done;
  logic                w_warm_done;
  logic                w_fwd;
  logic                w_pdfd_flush;

  // A same-cycle write is folded into the bank seen by a commit.
  always_comb begin
    w_ready   = ~reset & (r_state != S_FLUSH);
    w_wr      = bus.io_cfgValid & w_ready;
    w_addr_ok = (32'(bus.io_cfgAddr) < NUM_TAPS);
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (w_wr && w_addr_ok && (bus.io_cfgAddr == 4'(i))) begin
        w_shadow_nxt[i] = bus.io_cfgData;
        w_mask_nxt[i]   = 1'b1;
      end else begin
        w_shadow_nxt[i] = r_shadow[i];
        w_mask_nxt[i]   = r_mask[i];
      end
    end
    w_commit_ok  = bus.io_cfgCommit & (r_state != S_FLUSH) & (&w_mask_nxt);
    w_commit_bad = bus.io_cfgCommit & (r_state != S_FLUSH) & ~(&w_mask_nxt);
    w_flush_done = (r_fcnt == FCW'(FLUSH_CYCLES - 1));
    w_warm_done  = bus.io_pdfdValid & (r_wcnt == WCW'(WARMUP_SYMS - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_UNCONF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pdfd_flush = 1'b0;
    w_fwd        = 1'b0;
    case (r_state)
      S_UNCONF: begin
        w_pdfd_flush = 1'b1;
        if (w_commit_ok) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_pdfd_flush = 1'b1;
        if (w_flush_done) w_state_nxt = S_WARMUP;
      end
      S_WARMUP: begin
        if (w_commit_ok)      w_state_nxt = S_FLUSH;
        else if (w_warm_done) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_fwd = bus.io_pdfdValid & ~w_commit_ok;
        if (w_commit_ok) w_state_nxt = S_FLUSH;
      end
      default: w_state_nxt = S_UNCONF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
      r_mask     <= '0;
      r_err      <= 1'b0;
      r_fcnt     <= '0;
      r_wcnt     <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (w_commit_ok) r_live[i] <= w_shadow_nxt[i];
      end
      r_mask <= w_mask_nxt;
      if ((w_wr && !w_addr_ok) || w_commit_bad) r_err <= 1'b1;
      r_fcnt <= (r_state == S_FLUSH) ? r_fcnt + 1'b1 : '0;
      // Warm-up count restarts on any re-flush and never runs past its limit.
      if ((r_state != S_WARMUP) || w_commit_ok) begin
        r_wcnt <= '0;
      end else if (bus.io_pdfdValid && (r_wcnt != WCW'(WARMUP_SYMS))) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      r_rx_valid <= w_fwd;
      if (w_fwd) r_rx_data <= bus.io_pdfdData;
    end
  end

`ifdef PDFD_CTRL_STATS_EN
  logic [15:0] r_sym_cnt;

  always_ff @(posedge clock) begin
    if (reset || w_commit_ok) begin
      r_sym_cnt <= '0;
    end else if (r_rx_valid && (r_sym_cnt != 16'hFFFF)) begin
      r_sym_cnt <= r_sym_cnt + 16'd1;
    end
  end

  assign bus.io_symCount = r_sym_cnt;
`else
  // Statistics counter not built in this configuration.
`endif

  generate
    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_taps
      assign bus.io_taps[g] = r_live[g];
    end
  endgenerate

  assign bus.io_cfgReady  = w_ready;
  assign bus.io_cfgErr    = r_err;
  assign bus.io_pdfdFlush = w_pdfd_flush;
  assign bus.io_rxData    = r_rx_data;
  assign bus.io_rxValid   = r_rx_valid;
  assign bus.io_state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pdfd_tap_ctrl.sv
// ============================================================================
//  Module   : tb_pdfd_tap_ctrl
//  Brief    : Directed bench for pdfd_tap_ctrl with an output scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdfd_tap_ctrl;

  localparam int NT = 14;

  logic       clk;
  logic       rst;
  int         n_cmp;
  int         n_bad;
  logic [7:0] exp_q [$];
  logic [7:0] exp_taps [NT];

  pdfd_tap_ctrl_if #(.NUM_TAPS(NT), .TAP_W(8)) bus ();

  pdfd_tap_ctrl #(
    .NUM_TAPS(NT), .TAP_W(8), .FLUSH_CYCLES(4), .WARMUP_SYMS(16)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_taps(input string tag);
    for (int i = 0; i < NT; i++)
      chk($sformatf("%s_tap%0d", tag, i), 32'(bus.io_taps[i]), 32'(exp_taps[i]));
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    int k;
    k = 0;
    bus.io_cfgValid = 1'b1;
    bus.io_cfgAddr  = a;
    bus.io_cfgData  = d;
    while ((bus.io_cfgReady !== 1'b1) && (k < 20)) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wr_ready_timeout: ready %b after 20 cycles, expected 1", bus.io_cfgReady);
    end else begin
      tick();
    end
    bus.io_cfgValid = 1'b0;
  endtask

  task automatic commit();
    bus.io_cfgCommit = 1'b1;
    tick();
    bus.io_cfgCommit = 1'b0;
  endtask

  task automatic sym(input logic [7:0] d, input bit expect_out);
    if (expect_out) exp_q.push_back(d);
    bus.io_pdfdValid = 1'b1;
    bus.io_pdfdData  = d;
    tick();
    bus.io_pdfdValid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every io_rxValid must match the oldest expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.io_rxValid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rx_unexpected: got rxValid with data %0h, expected no output", bus.io_rxData);
        end else begin
          e = exp_q.pop_front();
          if (bus.io_rxData !== e) begin
            n_bad++;
            $display("FAIL rx_data: got %0h, expected %0h", bus.io_rxData, e);
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < NT; i++) exp_taps[i] = 8'h00;
    bus.io_cfgValid  = 1'b0;
    bus.io_cfgAddr   = 4'd0;
    bus.io_cfgData   = 8'h00;
    bus.io_cfgCommit = 1'b0;
    bus.io_pdfdValid = 1'b0;
    bus.io_pdfdData  = 8'h00;
    rst = 1'b1;

    // T1 reset
    repeat (2) tick();
    chk("rst_state",  32'(bus.io_state),     32'd0);
    chk("rst_flush",  32'(bus.io_pdfdFlush), 32'd1);
    chk("rst_rxv",    32'(bus.io_rxValid),   32'd0);
    chk("rst_rxd",    32'(bus.io_rxData),    32'd0);
    chk("rst_err",    32'(bus.io_cfgErr),    32'd0);
    chk("rst_ready",  32'(bus.io_cfgReady),  32'd0);
    chk_taps("rst");
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.io_cfgReady), 32'd1);

    // T4 bad address
    wr(4'd15, 8'h7F);
    chk("badaddr_err",   32'(bus.io_cfgErr), 32'd1);
    chk("badaddr_state", 32'(bus.io_state),  32'd0);
    chk_taps("badaddr");
    do_reset();
    chk("reset_clears_err", 32'(bus.io_cfgErr), 32'd0);

    // T3 premature commit
    for (int i = 0; i < 13; i++) wr(4'(i), 8'(i + 1));
    commit();
    chk("premature_state", 32'(bus.io_state), 32'd0);
    chk("premature_err",   32'(bus.io_cfgErr), 32'd1);
    chk_taps("premature");
    do_reset();

    // T2 bring-up
    for (int i = 0; i < NT; i++) wr(4'(i), 8'(i + 1));
    commit();
    for (int i = 0; i < NT; i++) exp_taps[i] = 8'(i + 1);
    chk("bringup_state_flush", 32'(bus.io_state),     32'd1);
    chk("bringup_flush",       32'(bus.io_pdfdFlush), 32'd1);
    chk("bringup_ready_flush", 32'(bus.io_cfgReady),  32'd0);
    chk_taps("bringup");
    commit();
    chk("flush_commit_no_err", 32'(bus.io_cfgErr), 32'd0);
    tick();
    tick();
    chk("flush_last_cycle", 32'(bus.io_state), 32'd1);
    tick();
    chk("warmup_state", 32'(bus.io_state),     32'd2);
    chk("warmup_flush", 32'(bus.io_pdfdFlush), 32'd0);
    chk("warmup_ready", 32'(bus.io_cfgReady),  32'd1);
    for (int i = 0; i < 15; i++) sym(8'(8'h10 + i), 1'b0);
    chk("warmup_15", 32'(bus.io_state), 32'd2);
    sym(8'h1F, 1'b0);
    chk("run_entry", 32'(bus.io_state), 32'd3);
    sym(8'hA5, 1'b1);
    sym(8'h3C, 1'b1);
    tick();
    sym(8'h00, 1'b1);
    sym(8'hFF, 1'b1);
    tick();
    chk("run_idle_rxv",  32'(bus.io_rxValid), 32'd0);
    chk("run_hold_rxd",  32'(bus.io_rxData),  32'hFF);
`ifdef PDFD_CTRL_STATS_EN
    chk("symcount_4", 32'(bus.io_symCount), 32'd4);
`endif

    // T5 retune in RUN: write + commit + a decoder valid, all in one cycle
    bus.io_cfgValid  = 1'b1;
    bus.io_cfgAddr   = 4'd3;
    bus.io_cfgData   = 8'hFB;
    bus.io_cfgCommit = 1'b1;
    bus.io_pdfdValid = 1'b1;
    bus.io_pdfdData  = 8'h77;
    tick();
    bus.io_cfgValid  = 1'b0;
    bus.io_cfgCommit = 1'b0;
    bus.io_pdfdValid = 1'b0;
    exp_taps[3] = 8'hFB;
    chk("retune_state", 32'(bus.io_state),   32'd1);
    chk("retune_rxv",   32'(bus.io_rxValid), 32'd0);
    chk("retune_err",   32'(bus.io_cfgErr),  32'd0);
    chk_taps("retune");
`ifdef PDFD_CTRL_STATS_EN
    chk("symcount_clr", 32'(bus.io_symCount), 32'd0);
`endif
    repeat (4) tick();
    chk("retune_warmup", 32'(bus.io_state), 32'd2);
    for (int i = 0; i < 16; i++) sym(8'(8'h40 + i), 1'b0);
    chk("retune_run", 32'(bus.io_state), 32'd3);
    sym(8'h5A, 1'b1);
    tick();
`ifdef PDFD_CTRL_STATS_EN
    chk("symcount_1", 32'(bus.io_symCount), 32'd1);
`endif

    // T6 reset during WARMUP
    commit();
    repeat (4) tick();
    chk("t6_warmup", 32'(bus.io_state), 32'd2);
    for (int i = 0; i < 5; i++) sym(8'h11, 1'b0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < NT; i++) exp_taps[i] = 8'h00;
    chk("t6_state", 32'(bus.io_state),     32'd0);
    chk("t6_flush", 32'(bus.io_pdfdFlush), 32'd1);
    chk("t6_rxv",   32'(bus.io_rxValid),   32'd0);
    chk("t6_err",   32'(bus.io_cfgErr),    32'd0);
    chk_taps("t6");
    rst = 1'b0;
    tick();
    commit();
    chk("t6_commit_err",   32'(bus.io_cfgErr), 32'd1);
    chk("t6_commit_state", 32'(bus.io_state),  32'd0);

    repeat (3) tick();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
